// File: rtl/axi_adapter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_adapter_pkg : AXI response codes, response merge helper, FSM state type
// Revision: 1.0
// ---------------------------------------------------------------------------
package axi_adapter_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Encodings are ordered by severity, so the numeric maximum is the merge.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/r_lane_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// r_lane_pack : lane buffer with clear, single-lane write and parallel read
// Revision: 1.0
// ---------------------------------------------------------------------------
module r_lane_pack #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_lane,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [LANES*DATA_W-1:0]   rd_data
);

  logic [LANES-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_lane] <= wr_data;
    end
  end

  assign rd_data = mem;

endmodule
`default_nettype wire

// File: rtl/axi_r_upsizer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_r_upsizer : packs narrow slave R beats into wide master R beats
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi_r_upsizer
  import axi_adapter_pkg::*;
#(
  parameter int S_DATA_WIDTH = 32,
  parameter int M_DATA_WIDTH = 128,
  parameter int RID_WIDTH    = 3,
  parameter int RESP_WIDTH   = 2,
  parameter int TXN_W        = 3,
  localparam int RATIO       = M_DATA_WIDTH / S_DATA_WIDTH,
  localparam int LANE_W      = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic [RID_WIDTH-1:0]    s_rid,
  input  logic [S_DATA_WIDTH-1:0] s_rdata,
  input  logic [RESP_WIDTH-1:0]   s_rresp,
  input  logic                    s_rlast,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  output logic [RID_WIDTH-1:0]    m_rid,
  output logic [M_DATA_WIDTH-1:0] m_rdata,
  output logic [RESP_WIDTH-1:0]   m_rresp,
  output logic                    m_rlast,
  output logic                    m_rvalid,
  input  logic                    m_rready,
  input  logic                    cmd_valid,
  input  logic [LANE_W-1:0]       cmd_start_lane,
  input  logic [TXN_W-1:0]        cmd_sub_txn,
  output logic                    cmd_ready,
  output logic                    busy
);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || RATIO * S_DATA_WIDTH != M_DATA_WIDTH
      || RESP_WIDTH != 2) begin : g_bad_params
    $error("axi_r_upsizer: width ratio must be a power of two >= 2 and RESP_WIDTH must be 2");
  end

  state_t                    state;
  logic [LANE_W-1:0]         lane;
  logic [TXN_W-1:0]          txn_left;
  logic [RESP_WIDTH-1:0]     resp_acc;
  logic [M_DATA_WIDTH-1:0]   buf_rd;
  logic [M_DATA_WIDTH-1:0]   packed_beat;
  logic [RESP_WIDTH-1:0]     resp_merged;
  logic                      s_hs;
  logic                      is_final;
  logic                      is_close;
  logic                      buf_clear;

  assign s_rready  = (state == ST_PACK);
  assign m_rvalid  = (state == ST_OUT);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  assign s_hs        = s_rvalid && s_rready;
  assign is_final    = s_rlast && (txn_left == '0);
  assign is_close    = is_final || (lane == LANE_W'(RATIO - 1));
  assign resp_merged = resp_max(resp_acc, s_rresp);
  assign buf_clear   = ((state == ST_IDLE) && cmd_valid)
                     || ((state == ST_OUT) && m_rready && !m_rlast);

  // The closing slave beat goes straight into the output register alongside
  // the buffered lanes, so the master beat appears one cycle after it.
  always_comb begin
    packed_beat = buf_rd;
    packed_beat[int'(lane) * S_DATA_WIDTH +: S_DATA_WIDTH] = s_rdata;
  end

  r_lane_pack #(
    .LANES  (RATIO),
    .DATA_W (S_DATA_WIDTH),
    .IDX_W  (LANE_W)
  ) u_lane_pack (
    .clk     (aclk),
    .rst     (arst),
    .clear   (buf_clear),
    .wr_en   (s_hs),
    .wr_lane (lane),
    .wr_data (s_rdata),
    .rd_data (buf_rd)
  );

  always_ff @(posedge aclk) begin
    if (arst) begin
      state    <= ST_IDLE;
      lane     <= '0;
      txn_left <= '0;
      resp_acc <= '0;
      m_rdata  <= '0;
      m_rid    <= '0;
      m_rresp  <= '0;
      m_rlast  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            lane     <= cmd_start_lane;
            txn_left <= cmd_sub_txn;
            resp_acc <= '0;
            state    <= ST_PACK;
          end
        end
        ST_PACK: begin
          if (s_hs) begin
            if (s_rlast && (txn_left != '0)) begin
              txn_left <= txn_left - 1'b1;
            end
            if (is_close) begin
              m_rdata <= packed_beat;
              m_rresp <= resp_merged;
              m_rid   <= s_rid;
              m_rlast <= is_final;
              state   <= ST_OUT;
            end else begin
              resp_acc <= resp_merged;
              lane     <= lane + 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (m_rready) begin
            if (m_rlast) begin
              state <= ST_IDLE;
            end else begin
              lane     <= '0;
              resp_acc <= '0;
              state    <= ST_PACK;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/axi_r_upsizer.md
AXI_R_UPSIZER -- requirements
Module: axi_r_upsizer

Interface
REQ-001 SHALL have parameter S_DATA_WIDTH, default 32, slave-side read data width.
REQ-002 SHALL have parameter M_DATA_WIDTH, default 128, master-side read data width.
REQ-003 SHALL have parameters RID_WIDTH (default 3), RESP_WIDTH (default 2) and TXN_W (default 3, width of the sub-transaction count).
REQ-004 SHALL derive RATIO = M_DATA_WIDTH/S_DATA_WIDTH and LANE_W = clog2(RATIO), and SHALL fail elaboration unless RATIO is a power of two and at least 2.
REQ-005 SHALL have one clock and a synchronous, active-high reset: aclk (input, 1 bit, clock) and arst (input, 1 bit, reset).
REQ-006 SHALL have the slave R inputs s_rid (RID_WIDTH), s_rdata (S_DATA_WIDTH), s_rresp (RESP_WIDTH), s_rlast (1) and s_rvalid (1), and the output s_rready (1).
REQ-007 SHALL have the master R outputs m_rid (RID_WIDTH), m_rdata (M_DATA_WIDTH), m_rresp (RESP_WIDTH), m_rlast (1) and m_rvalid (1), and the input m_rready (1).
REQ-008 SHALL have the command inputs cmd_valid (1), cmd_start_lane (LANE_W, first lane of the first master beat) and cmd_sub_txn (TXN_W, number of slave sub-bursts minus 1), and the output cmd_ready (1).
REQ-009 SHALL have output busy (1), high whenever the state is not IDLE.

Function
REQ-010 SHALL implement a three-state machine: IDLE, PACK, OUT.
REQ-011 IDLE: cmd_ready=1; on cmd_valid, SHALL capture lane=cmd_start_lane and txn_left=cmd_sub_txn, clear the lane buffer, and go to PACK.
REQ-012 PACK: s_rready=1, cmd_ready=0, m_rvalid=0.
REQ-013 On each slave handshake, SHALL write s_rdata into lane `lane` of the buffer, latch s_rid, and merge s_rresp into the beat response by taking the maximum encoding (DECERR > SLVERR > EXOKAY > OKAY).
REQ-014 A slave handshake with s_rlast=1 and txn_left>0 SHALL decrement txn_left and SHALL NOT close the current master beat.
REQ-015 A slave handshake with s_rlast=1 and txn_left=0 is the final beat: SHALL close the master beat with last=1.
REQ-016 A slave handshake on lane RATIO-1 SHALL close the master beat with last=0, unless REQ-015 applies.
REQ-017 A non-closing slave handshake SHALL increment lane by 1.
REQ-018 On close, SHALL load the buffer, merged response, latched id and the last flag into the output register, and go to OUT; m_rvalid SHALL rise the cycle after the closing slave handshake.
REQ-019 OUT: m_rvalid=1 and s_rready=0; m_rdata, m_rid, m_rresp and m_rlast SHALL stay stable until m_rready=1.
REQ-020 On the OUT handshake with last=0, SHALL set lane=0, clear the buffer and merged response, and return to PACK.
REQ-021 On the OUT handshake with last=1, SHALL go to IDLE; a new command SHALL NOT be accepted in that same cycle.
REQ-022 Lanes not written in a master beat SHALL read as zero, including lanes below cmd_start_lane and lanes above the final beat.
REQ-023 Lane k SHALL occupy m_rdata bits [(k+1)*S_DATA_WIDTH-1 : k*S_DATA_WIDTH].
REQ-024 The lane counter SHALL be LANE_W bits and SHALL never wrap in PACK, because reaching RATIO-1 closes the beat.
REQ-025 s_rdata, s_rlast and s_rvalid arriving in IDLE or OUT SHALL be ignored, because s_rready=0 in those states.
REQ-026 m_rresp SHALL reflect only the slave beats packed into that master beat, not a whole-burst accumulation.

Reset
REQ-027 While arst=1 at a rising edge of aclk, the block SHALL go to IDLE.
REQ-028 Reset SHALL drive m_rvalid, m_rlast, m_rdata, m_rid, m_rresp, s_rready, busy, the lane counter, txn_left and the buffer to 0, and cmd_ready to 1.
REQ-029 Reset mid-PACK or mid-OUT SHALL discard all partial data with no master beat emitted.

Structure
REQ-030 Package axi_adapter_pkg SHALL hold the RESP encodings (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), the resp_max function and the state enum.
REQ-031 The lane buffer SHALL be sub-module r_lane_pack.
REQ-032 r_lane_pack SHALL provide a clear, a write at a lane index, and a parallel read.

Verification (S=32, M=128)
REQ-033 start_lane=0, sub_txn=0, 8 beats 0x0..0x7, rlast on the 8th -> m_rdata 0x00000003_00000002_00000001_00000000 with m_rlast=0, then 0x7_6_5_4 lanes with m_rlast=1, m_rresp=0.
REQ-034 start_lane=2, beats 0xA,0xB,0xC, rlast on 0xC -> beat 1 = {0xB,0xA,0,0} (lanes 3..0) with m_rlast=0, then beat 2 = {0,0,0,0xC} with m_rlast=1.
REQ-035 sub_txn=1, two 2-beat bursts 1,2 | 3,4 with rlast on 2 and 4 -> a single master beat {4,3,2,1} with m_rlast=1, and m_rlast never asserted earlier.
REQ-036 Resps OKAY, SLVERR, EXOKAY, OKAY in one master beat -> m_rresp=2'b10.
REQ-037 m_rready held low 5 cycles in OUT -> m_rvalid and all m_* stable, s_rready=0 throughout, no slave beat consumed.
REQ-038 arst pulsed after 2 slave beats -> all outputs 0 and cmd_ready=1 next cycle; the following command produces only fresh data with no stale lanes.
